hazard_stall_unit: RTL and testbench

//  Pipeline hazard controller for the 5-stage MIPS core; the stall side of operand

---
 rtl/hazard_stall_unit.sv | 99 +++++++++
 tb/tb_hazard_stall_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Load-use stall and branch/jump flush controller for the ID stage of a 5-stage MIPS pipeline.
// Stalls freeze PC and IF/ID and inject an ID/EX bubble; taken branches/jumps flush IF/ID.
module hazard_stall_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_Rs,
    input  logic [4:0]       id_Rt,
    input  logic             id_uses_Rt,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_Rt,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             ifIdFlush,
    output logic             idExBubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int CW = (LOAD_STALL_CYCLES < 2) ? 1 : $clog2(LOAD_STALL_CYCLES + 1);

    typedef enum logic {IDLE, STALL} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             hazard;
    logic             stall_active;
    logic             flush;

    // $zero is never a real producer, so a load to r0 cannot create a hazard.
    assign hazard = ex_memRead && (ex_Rt != 5'd0) &&
                    ((ex_Rt == id_Rs) || (id_uses_Rt && (ex_Rt == id_Rt)));

    assign stall_active = (state_q == STALL) || hazard;
    assign flush        = (branch_taken || jump) && !stall_active;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hazard && (LOAD_STALL_CYCLES > 1)) begin
                    state_d = STALL;
                    cnt_d   = CW'(LOAD_STALL_CYCLES - 1);
                end
            end
            STALL: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_active && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
        if (flush && (flush_count_q != '1))        flush_count_d = flush_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Reset overrides everything so the pipeline free-runs while held in reset.
    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        if (!rst) begin
            pcWrite    = !stall_active;
            ifIdWrite  = !stall_active;
            ifIdFlush  = flush;
            idExBubble = stall_active;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Drives two hazard_stall_unit configurations (LSC=1/CNT_W=16 and LSC=3/CNT_W=4) with shared
// directed and random stimulus, comparing against a countdown-based reference model.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_Rs, id_Rt, ex_Rt;
    logic       id_uses_Rt, ex_memRead, branch_taken, jump;

    logic        pw1, iw1, fl1, bb1, pw3, iw3, fl3, bb3;
    logic [15:0] sc1, fc1;
    logic [3:0]  sc3, fc3;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // reference model state, index 0 = LSC 1, index 1 = LSC 3
    int lsc  [2] = '{1, 3};
    int cmax [2] = '{65535, 15};
    int rem  [2] = '{0, 0};
    int scnt [2] = '{0, 0};
    int fcnt [2] = '{0, 0};

    always #5 clk = ~clk;

    hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_Rt(id_uses_Rt),
        .ex_memRead(ex_memRead), .ex_Rt(ex_Rt), .branch_taken(branch_taken), .jump(jump),
        .pcWrite(pw1), .ifIdWrite(iw1), .ifIdFlush(fl1), .idExBubble(bb1),
        .stall_count(sc1), .flush_count(fc1)
    );

    hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_Rt(id_uses_Rt),
        .ex_memRead(ex_memRead), .ex_Rt(ex_Rt), .branch_taken(branch_taken), .jump(jump),
        .pcWrite(pw3), .ifIdWrite(iw3), .ifIdFlush(fl3), .idExBubble(bb3),
        .stall_count(sc3), .flush_count(fc3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic r, input int rs, input int rt, input logic uses,
                         input logic mr, input int ert, input logic br, input logic j);
        rst          = r;
        id_Rs        = 5'(rs);
        id_Rt        = 5'(rt);
        id_uses_Rt   = uses;
        ex_memRead   = mr;
        ex_Rt        = 5'(ert);
        branch_taken = br;
        jump         = j;
    endtask

    // Sample at the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit          haz, stalled, fl;
        logic [3:0]  obs, exp;
        logic [31:0] osc, ofc;
        @(negedge clk);
        haz = ex_memRead && ex_Rt != 0 &&
              (ex_Rt == id_Rs || (id_uses_Rt && ex_Rt == id_Rt));
        for (int d = 0; d < 2; d++) begin
            stalled = !rst && (rem[d] > 0 || haz);
            fl      = !rst && (branch_taken || jump) && !stalled;
            exp     = {!stalled, !stalled, fl, stalled};
            obs     = (d == 0) ? {pw1, iw1, fl1, bb1} : {pw3, iw3, fl3, bb3};
            osc     = (d == 0) ? 32'(sc1) : 32'(sc3);
            ofc     = (d == 0) ? 32'(fc1) : 32'(fc3);
            chk(d == 0 ? "ctl_lsc1" : "ctl_lsc3", 32'(obs), 32'(exp));
            chk(d == 0 ? "stallcnt_lsc1" : "stallcnt_lsc3", osc, 32'(scnt[d]));
            chk(d == 0 ? "flushcnt_lsc1" : "flushcnt_lsc3", ofc, 32'(fcnt[d]));
            if (rst) begin
                rem[d] = 0; scnt[d] = 0; fcnt[d] = 0;
            end else begin
                if (rem[d] > 0) rem[d]--;
                else if (haz)   rem[d] = lsc[d] - 1;
                if (stalled && scnt[d] < cmax[d]) scnt[d]++;
                if (fl && fcnt[d] < cmax[d])      fcnt[d]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        // reset forces pass-through even with a hazard and a jump present
        drive(1, 2, 0, 0, 1, 2, 0, 1); step();
        // lw $2 then add $3,$2,$4
        drive(0, 2, 4, 1, 1, 2, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();
        // addi reading only Rs; Rt match must not stall
        drive(0, 1, 5, 0, 1, 5, 0, 0); step();
        // load to $zero never stalls
        drive(0, 0, 0, 1, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        // branch during hazard is held off, then flushes
        drive(0, 7, 0, 0, 1, 7, 1, 0); step();
        drive(0, 7, 0, 0, 0, 7, 1, 0); step(); step(); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        // jump without hazard
        drive(0, 0, 0, 0, 0, 0, 0, 1); step();
        // hazard pulse, reset in 2nd cycle of the long stall
        drive(0, 3, 0, 0, 1, 3, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        // hazard held across exit of the long stall
        drive(0, 3, 0, 0, 1, 3, 0, 0); repeat (8) step();
        // flush counter saturation in the 4-bit instance
        drive(0, 0, 0, 0, 0, 0, 0, 1); repeat (20) step();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) < 2,
                  $urandom_range(3), $urandom_range(3), 1'($urandom),
                  $urandom_range(99) < 50, $urandom_range(3),
                  $urandom_range(99) < 20, $urandom_range(99) < 10);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
